fsmc_sdram_bridge: RTL and testbench

- Slave for the STM32 FSMC asynchronous SRAM-style bus (NE1/NWE/NOE/NBL, 16-bit A/D).
- Converts each FSMC access into a single-word request/acknowledge transaction for the downstream SDRAM controller.
- Sits between the `fsmc_*` pins of `system` and the SDRAM controller's user port.
- Holds the MCU through FSMC NWAIT until a write is accepted or read data is valid.

---
 rtl/fsmc_sdram_bridge_if.sv | 32 +++
 rtl/fsmc_sdram_bridge.sv | 199 +++++++++++++++++++
 tb/tb_fsmc_sdram_bridge.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fsmc_sdram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : fsmc_sdram_bridge_if
// Purpose  : Single-word request/acknowledge port between the FSMC bridge
//            (master) and the SDRAM controller user port (slave).
// Signals  : req, req_we, req_addr[ADDR_W], req_wdata[16], req_be[2]
//            (master -> slave); ack, rd_data[16], rd_valid (slave -> master)
// Revision : 1.0  initial release
// ============================================================================
interface fsmc_sdram_bridge_if #(
  parameter int ADDR_W = 22
);
  logic              req;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic [1:0]        req_be;
  logic              ack;
  logic [15:0]       rd_data;
  logic              rd_valid;

  modport master (
    output req, req_we, req_addr, req_wdata, req_be,
    input  ack, rd_data, rd_valid
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, req_be,
    output ack, rd_data, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/fsmc_sdram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : fsmc_sdram_bridge
// Purpose  : STM32 FSMC asynchronous SRAM-style slave. Each NE1 assertion is
//            turned into one single-word request to the SDRAM controller; the
//            MCU is held on NWAIT until the write is accepted or read data is
//            available.
// Ports    : clk, rst (async, active low)
//            fsmc_a[16], fsmc_d[16] (inout), fsmc_ne1/nwe/noe/nbl1/nbl0 in,
//            fsmc_nwait out (0 = stall)
//            sd  : SDRAM user port (master modport)
//            err : sticky error (illegal strobe combination or read timeout)
// Revision : 1.0  initial release
// ============================================================================
module fsmc_sdram_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 22,
  parameter int RD_TIMEOUT  = 1023
) (
  input  wire         clk,
  input  wire         rst,
  input  wire  [15:0] fsmc_a,
  inout  wire  [15:0] fsmc_d,
  input  wire         fsmc_ne1,
  input  wire         fsmc_nwe,
  input  wire         fsmc_noe,
  input  wire         fsmc_nbl1,
  input  wire         fsmc_nbl0,
  output logic        fsmc_nwait,
  fsmc_sdram_bridge_if.master sd,
  output logic        err
);

  localparam int          c_cnt_w    = $clog2(RD_TIMEOUT + 1);
  localparam [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RD_TIMEOUT - 1);
  localparam [15:0]        c_rd_abort = 16'hDEAD;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DONE    = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_ne1_sync, r_nwe_sync, r_noe_sync;
  logic                   w_s_ne1, w_s_nwe, w_s_noe;

  logic              r_req, w_req_nxt;
  logic              r_req_we, w_req_we_nxt;
  logic [ADDR_W-1:0] r_req_addr, w_req_addr_nxt;
  logic [15:0]       r_req_wdata, w_req_wdata_nxt;
  logic [1:0]        r_req_be, w_req_be_nxt;
  logic              r_err, w_err_nxt;
  logic [15:0]       r_rd_data, w_rd_data_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] w_addr_ext;
  logic              w_d_oe;

  // FSMC word address zero-extended to the controller address width.
  generate
    if (ADDR_W > 16) begin : g_addr_ext
      assign w_addr_ext = {{(ADDR_W-16){1'b0}}, fsmc_a};
    end else begin : g_addr_trunc
      assign w_addr_ext = fsmc_a[ADDR_W-1:0];
    end
  endgenerate

  // Strobe synchronizers; reset to the inactive (high) level so no access
  // is seen coming out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ne1_sync <= '1;
      r_nwe_sync <= '1;
      r_noe_sync <= '1;
    end else begin
      r_ne1_sync <= {r_ne1_sync[SYNC_STAGES-2:0], fsmc_ne1};
      r_nwe_sync <= {r_nwe_sync[SYNC_STAGES-2:0], fsmc_nwe};
      r_noe_sync <= {r_noe_sync[SYNC_STAGES-2:0], fsmc_noe};
    end
  end

  assign w_s_ne1 = r_ne1_sync[SYNC_STAGES-1];
  assign w_s_nwe = r_nwe_sync[SYNC_STAGES-1];
  assign w_s_noe = r_noe_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_be    <= '0;
      r_err       <= 1'b0;
      r_rd_data   <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_req_we    <= w_req_we_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_req_wdata <= w_req_wdata_nxt;
      r_req_be    <= w_req_be_nxt;
      r_err       <= w_err_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = r_req;
    w_req_we_nxt    = r_req_we;
    w_req_addr_nxt  = r_req_addr;
    w_req_wdata_nxt = r_req_wdata;
    w_req_be_nxt    = r_req_be;
    w_err_nxt       = r_err;
    w_rd_data_nxt   = r_rd_data;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (!w_s_ne1) begin
          if (!w_s_nwe && !w_s_noe) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_RELEASE;
          end else if (!w_s_nwe) begin
            // Address, data and lanes are stable for the whole strobe, so
            // they are taken straight off the pins.
            w_req_addr_nxt  = w_addr_ext;
            w_req_wdata_nxt = fsmc_d;
            w_req_be_nxt    = ~{fsmc_nbl1, fsmc_nbl0};
            w_req_we_nxt    = 1'b1;
            w_req_nxt       = 1'b1;
            w_state_nxt     = ST_WR_REQ;
          end else if (!w_s_noe) begin
            w_req_addr_nxt = w_addr_ext;
            w_req_we_nxt   = 1'b0;
            w_req_nxt      = 1'b1;
            w_state_nxt    = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (sd.ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        if (sd.ack) begin
          w_req_nxt = 1'b0;
          w_cnt_nxt = '0;
          if (sd.rd_valid) begin
            w_rd_data_nxt = sd.rd_data;
            w_state_nxt   = ST_DONE;
          end else begin
            w_state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (sd.rd_valid) begin
          w_rd_data_nxt = sd.rd_data;
          w_state_nxt   = ST_DONE;
        end else if (r_cnt == c_cnt_last) begin
          // Give the MCU a recognisable pattern instead of hanging it.
          w_err_nxt     = 1'b1;
          w_rd_data_nxt = c_rd_abort;
          w_state_nxt   = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE, ST_RELEASE: begin
        if (w_s_ne1) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Raw pins are used here so the MCU is stalled and released without the
  // synchronizer delay.
  assign fsmc_nwait = !(!fsmc_ne1 && (r_state != ST_DONE));
  assign w_d_oe     = (r_state == ST_DONE) && !r_req_we && !fsmc_ne1 && !fsmc_noe;
  assign fsmc_d     = w_d_oe ? r_rd_data : 16'hzzzz;

  assign sd.req       = r_req;
  assign sd.req_we    = r_req_we;
  assign sd.req_addr  = r_req_addr;
  assign sd.req_wdata = r_req_wdata;
  assign sd.req_be    = r_req_be;
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fsmc_sdram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsmc_sdram_bridge
// Purpose  : Self-checking bench for fsmc_sdram_bridge: table of FSMC
//            accesses against a scripted SDRAM controller, plus hand-written
//            reset, illegal-strobe and read-timeout sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_fsmc_sdram_bridge;
  localparam int SYNC_STAGES = 2;
  localparam int ADDR_W      = 22;
  localparam int RD_TIMEOUT  = 1023;
  localparam logic [15:0] c_bus_idle = 16'hFFFF;  // pulled-up bus value

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] fsmc_a = '0;
  logic        fsmc_ne1 = 1'b1, fsmc_nwe = 1'b1, fsmc_noe = 1'b1;
  logic        fsmc_nbl1 = 1'b1, fsmc_nbl0 = 1'b1;
  logic        fsmc_nwait;
  logic        err;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_d = '0;
  tri1  [15:0] fsmc_d;

  assign fsmc_d = tb_oe ? tb_d : 16'hzzzz;

  fsmc_sdram_bridge_if #(.ADDR_W(ADDR_W)) sd_if ();

  fsmc_sdram_bridge #(
    .SYNC_STAGES(SYNC_STAGES), .ADDR_W(ADDR_W), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .fsmc_a(fsmc_a), .fsmc_d(fsmc_d),
    .fsmc_ne1(fsmc_ne1), .fsmc_nwe(fsmc_nwe), .fsmc_noe(fsmc_noe),
    .fsmc_nbl1(fsmc_nbl1), .fsmc_nbl0(fsmc_nbl0),
    .fsmc_nwait(fsmc_nwait),
    .sd(sd_if.master),
    .err(err)
  );

  always #5 clk = ~clk;

  // Count rising edges of req.
  int   req_cnt = 0;
  logic req_q   = 1'b0;
  always @(posedge clk) begin
    req_q <= sd_if.req;
    if (sd_if.req && !req_q) req_cnt <= req_cnt + 1;
  end

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  nbl;      // {nbl1, nbl0}
    int          ack_dly;  // cycles from req seen to ack
    int          rdv_dly;  // cycles from ack to rd_valid (0 = same cycle)
    logic [15:0] rdata;
    logic [1:0]  exp_be;
  } vec_t;

  vec_t vecs [6];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic ctrl_idle();
    sd_if.ack      = 1'b0;
    sd_if.rd_valid = 1'b0;
    sd_if.rd_data  = 16'h1234;
  endtask

  // Wait (bounded) for req; returns number of negedges waited.
  task automatic wait_req(output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (sd_if.req) seen = 1'b1;
    end
  endtask

  task automatic do_access(input vec_t v, input string tag);
    int base;
    int lat;
    base = req_cnt;
    @(negedge clk);
    fsmc_a    = v.addr;
    fsmc_nbl1 = v.nbl[1];
    fsmc_nbl0 = v.nbl[0];
    if (v.is_wr) begin
      tb_d     = v.wdata;
      tb_oe    = 1'b1;
      fsmc_nwe = 1'b0;
    end else begin
      fsmc_noe = 1'b0;
    end
    fsmc_ne1 = 1'b0;
    wait_req(lat);
    chk({tag, " req latency"}, lat, SYNC_STAGES + 1);
    repeat (v.ack_dly) @(negedge clk);
    chk({tag, " nwait stall"}, {31'b0, fsmc_nwait}, 32'd0);
    chk({tag, " req held"}, {31'b0, sd_if.req}, 32'd1);
    chk({tag, " req_we"}, {31'b0, sd_if.req_we}, {31'b0, v.is_wr});
    chk({tag, " req_addr"}, {10'b0, sd_if.req_addr}, {16'b0, v.addr});
    if (v.is_wr) begin
      chk({tag, " req_wdata"}, {16'b0, sd_if.req_wdata}, {16'b0, v.wdata});
      chk({tag, " req_be"}, {30'b0, sd_if.req_be}, {30'b0, v.exp_be});
    end
    sd_if.ack = 1'b1;
    if (!v.is_wr && v.rdv_dly == 0) begin
      sd_if.rd_valid = 1'b1;
      sd_if.rd_data  = v.rdata;
    end
    @(negedge clk);
    ctrl_idle();
    chk({tag, " req dropped"}, {31'b0, sd_if.req}, 32'd0);
    if (!v.is_wr && v.rdv_dly > 0) begin
      repeat (v.rdv_dly - 1) @(negedge clk);
      chk({tag, " nwait before rd_valid"}, {31'b0, fsmc_nwait}, 32'd0);
      sd_if.rd_valid = 1'b1;
      sd_if.rd_data  = v.rdata;
      @(negedge clk);
      ctrl_idle();
    end
    chk({tag, " nwait released"}, {31'b0, fsmc_nwait}, 32'd1);
    if (!v.is_wr) chk({tag, " fsmc_d read"}, {16'b0, fsmc_d}, {16'b0, v.rdata});
    fsmc_nwe = 1'b1;
    fsmc_noe = 1'b1;
    #1;
    if (!v.is_wr) chk({tag, " fsmc_d released"}, {16'b0, fsmc_d}, {16'b0, c_bus_idle});
    tb_oe = 1'b0;
    @(negedge clk);
    fsmc_ne1 = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    chk({tag, " one req"}, req_cnt - base, 32'd1);
  endtask

  task automatic start_read(input logic [15:0] addr);
    int lat;
    @(negedge clk);
    fsmc_a   = addr;
    fsmc_noe = 1'b0;
    fsmc_ne1 = 1'b0;
    wait_req(lat);
    chk("read req seen", {31'b0, sd_if.req}, 32'd1);
    sd_if.ack = 1'b1;
    @(negedge clk);
    ctrl_idle();
  endtask

  task automatic pulse_reset();
    #3 rst = 1'b0;
    #100;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int base;
    int cnt;
    vec_t wv;
    ctrl_idle();

    //                 wr    addr      wdata     nbl    ack rdv rdata    be
    vecs[0] = '{1'b1, 16'h0000, 16'hAAAA, 2'b00, 5, 0, 16'h0000, 2'b11};
    vecs[1] = '{1'b1, 16'h0001, 16'h5555, 2'b10, 1, 0, 16'h0000, 2'b01};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 1, 8, 16'hAAAA, 2'b00};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h1234, 2'b01, 0, 0, 16'h0000, 2'b10};
    vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 2'b00, 2, 0, 16'hBEEF, 2'b00};
    vecs[5] = '{1'b0, 16'h8000, 16'h0000, 2'b00, 0, 1, 16'h0F0F, 2'b00};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst req", {31'b0, sd_if.req}, 32'd0);
    chk("rst req_we", {31'b0, sd_if.req_we}, 32'd0);
    chk("rst req_addr", {10'b0, sd_if.req_addr}, 32'd0);
    chk("rst req_wdata", {16'b0, sd_if.req_wdata}, 32'd0);
    chk("rst req_be", {30'b0, sd_if.req_be}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    chk("rst nwait", {31'b0, fsmc_nwait}, 32'd1);
    chk("rst fsmc_d", {16'b0, fsmc_d}, {16'b0, c_bus_idle});
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) do_access(vecs[i], $sformatf("vec%0d", i));
    chk("no err after table", {31'b0, err}, 32'd0);

    // Reset in the middle of RD_WAIT.
    start_read(16'h0003);
    repeat (10) @(negedge clk);
    chk("rd_wait stall", {31'b0, fsmc_nwait}, 32'd0);
    fsmc_ne1 = 1'b1;
    fsmc_noe = 1'b1;
    #3 rst = 1'b0;
    #50;
    chk("mid rst req", {31'b0, sd_if.req}, 32'd0);
    chk("mid rst nwait", {31'b0, fsmc_nwait}, 32'd1);
    chk("mid rst fsmc_d", {16'b0, fsmc_d}, {16'b0, c_bus_idle});
    chk("mid rst err", {31'b0, err}, 32'd0);
    #50;
    @(negedge clk);
    rst = 1'b1;
    repeat (RD_TIMEOUT + 10) @(negedge clk);
    chk("no stale timeout", {31'b0, err}, 32'd0);

    // Illegal access: both strobes together.
    base = req_cnt;
    @(negedge clk);
    fsmc_ne1 = 1'b0;
    fsmc_nwe = 1'b0;
    fsmc_noe = 1'b0;
    repeat (SYNC_STAGES + 4) @(negedge clk);
    chk("illegal no req", req_cnt - base, 32'd0);
    chk("illegal req low", {31'b0, sd_if.req}, 32'd0);
    chk("illegal err", {31'b0, err}, 32'd1);
    fsmc_ne1 = 1'b1;
    fsmc_nwe = 1'b1;
    fsmc_noe = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    wv = '{1'b1, 16'h0077, 16'hC3C3, 2'b00, 2, 0, 16'h0000, 2'b11};
    do_access(wv, "post-illegal");
    chk("err sticky", {31'b0, err}, 32'd1);

    // Read timeout.
    pulse_reset();
    repeat (2) @(negedge clk);
    chk("err cleared by rst", {31'b0, err}, 32'd0);
    start_read(16'h0042);
    cnt = 1;
    while (fsmc_nwait == 1'b0 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
      if (cnt == RD_TIMEOUT / 2) chk("no early timeout", {31'b0, err}, 32'd0);
    end
    chk("timeout window", {31'b0, (cnt >= RD_TIMEOUT && cnt <= RD_TIMEOUT + 2)}, 32'd1);
    chk("timeout err", {31'b0, err}, 32'd1);
    chk("timeout fsmc_d", {16'b0, fsmc_d}, 32'h0000DEAD);
    fsmc_noe = 1'b1;
    #1;
    chk("timeout bus released", {16'b0, fsmc_d}, {16'b0, c_bus_idle});
    @(negedge clk);
    fsmc_ne1 = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
